// File: rtl/demux_pkg.sv
// +--------------------------------------------------------------------------+
// | demux_pkg : shared constants and types for the two-way stream demux.     |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package demux_pkg;
  localparam int DEFAULT_WIDTH = 4;

  typedef logic dest_t;

  localparam dest_t DEST_OUT0 = 1'b0;
  localparam dest_t DEST_OUT1 = 1'b1;
endpackage

`default_nettype wire

// File: rtl/stream_hold_reg.sv
// +--------------------------------------------------------------------------+
// | stream_hold_reg : single-entry valid/ready holding register (load/drain).|
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module stream_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;

  // Accept when empty, or when the held beat leaves in this same cycle.
  assign load_ready_o = ~valid_q | out_ready_i;
  assign load         = load_valid_i & load_ready_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/stream_demux_2.sv
// +--------------------------------------------------------------------------+
// | stream_demux_2 : routes a valid/ready stream to one of two outputs.      |
// | Optional per-output transfer counters with STREAM_DEMUX_2_COUNT_EN.       |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module stream_demux_2
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  dest_t            in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef STREAM_DEMUX_2_COUNT_EN
  ,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
`endif
);

  logic load0_valid, load1_valid;
  logic load0_ready, load1_ready;

  assign load0_valid = in_valid & (in_sel == DEST_OUT0);
  assign load1_valid = in_valid & (in_sel == DEST_OUT1);
  assign in_ready    = (in_sel == DEST_OUT1) ? load1_ready : load0_ready;

  stream_hold_reg #(.WIDTH(WIDTH)) u_hold0 (
    .clk          (clk),
    .reset        (reset),
    .load_valid_i (load0_valid),
    .load_ready_o (load0_ready),
    .load_data_i  (in_data),
    .out_valid_o  (out0_valid),
    .out_ready_i  (out0_ready),
    .out_data_o   (out0_data)
  );

  stream_hold_reg #(.WIDTH(WIDTH)) u_hold1 (
    .clk          (clk),
    .reset        (reset),
    .load_valid_i (load1_valid),
    .load_ready_o (load1_ready),
    .load_data_i  (in_data),
    .out_valid_o  (out1_valid),
    .out_ready_i  (out1_ready),
    .out_data_o   (out1_data)
  );

`ifdef STREAM_DEMUX_2_COUNT_EN
  logic [7:0] cnt0_q, cnt1_q;

  // Counters wrap naturally at 8 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      if (out0_valid && out0_ready) cnt0_q <= cnt0_q + 8'd1;
      if (out1_valid && out1_ready) cnt1_q <= cnt1_q + 8'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_2.sv
// +--------------------------------------------------------------------------+
// | tb_stream_demux_2 : directed, table-driven bench for stream_demux_2.     |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_stream_demux_2;
  import demux_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [3:0] in_data;
  dest_t      in_sel;
  logic       out0_valid, out0_ready, out1_valid, out1_ready;
  logic [3:0] out0_data, out1_data;
`ifdef STREAM_DEMUX_2_COUNT_EN
  logic [7:0] cnt0, cnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stream_demux_2 #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef STREAM_DEMUX_2_COUNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  typedef struct {
    logic       iv;
    logic       sel;
    logic [3:0] d;
    logic       r0;
    logic       r1;
    logic       e_ir;
    logic       e0v;
    logic [3:0] e0d;
    logic       e1v;
    logic [3:0] e1d;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e0v, input logic [3:0] e0d,
                          input logic e1v, input logic [3:0] e1d);
    chk({tag, " out0_valid"}, {7'd0, out0_valid}, {7'd0, e0v});
    chk({tag, " out0_data"},  {4'd0, out0_data},  {4'd0, e0d});
    chk({tag, " out1_valid"}, {7'd0, out1_valid}, {7'd0, e1v});
    chk({tag, " out1_data"},  {4'd0, out1_data},  {4'd0, e1d});
  endtask

  task automatic drive(input logic iv, input logic sel, input logic [3:0] d,
                       input logic r0, input logic r1);
    in_valid   = iv;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  initial begin
    // iv sel data r0 r1 | in_ready | out0 v,d | out1 v,d  (state after the edge)
    vecs[0]  = '{1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 4'h0};
    vecs[1]  = '{1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 4'h5};
    vecs[2]  = '{1'b1, 1'b0, 4'h9, 1'b1, 1'b1, 1'b1, 1'b1, 4'h9, 1'b0, 4'h5};
    vecs[3]  = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 4'h9, 1'b0, 4'h5};
    vecs[4]  = '{1'b1, 1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 1'b1, 4'h7};
    vecs[5]  = '{1'b1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 1'b1, 4'h7};
    vecs[6]  = '{1'b1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 1'b1, 4'h7};
    vecs[7]  = '{1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 4'h9, 1'b1, 4'h2};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 1'b1, 4'h2};
    vecs[9]  = '{1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 4'h2};
    vecs[10] = '{1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b1, 4'h2};
    vecs[11] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 4'h2};
    vecs[12] = '{1'b1, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 1'b1, 4'hB};

    reset = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    #1;
    chk_outs("reset", 1'b0, 4'h0, 1'b0, 4'h0);
`ifdef STREAM_DEMUX_2_COUNT_EN
    chk("reset cnt0", cnt0, 8'd0);
    chk("reset cnt1", cnt1, 8'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].sel, vecs[i].d, vecs[i].r0, vecs[i].r1);
      #1;
      chk($sformatf("vec%0d in_ready", i), {7'd0, in_ready}, {7'd0, vecs[i].e_ir});
      @(posedge clk);
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].e0v, vecs[i].e0d, vecs[i].e1v, vecs[i].e1d);
    end

    // out0 holds A, out1 holds B: async reset mid-cycle clears both at once.
    drive(1'b1, 1'b0, 4'h5, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_outs("async reset", 1'b0, 4'h0, 1'b0, 4'h0);
    @(posedge clk);
    #1;
    chk_outs("held in reset", 1'b0, 4'h0, 1'b0, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", {7'd0, in_ready}, 8'd1);
    chk_outs("before first edge", 1'b0, 4'h0, 1'b0, 4'h0);
    @(posedge clk);
    #1;
    chk_outs("first accept", 1'b1, 4'h5, 1'b0, 4'h0);

    // Stall a full out1, then stream eight beats to out0 back to back.
    @(negedge clk);
    drive(1'b1, 1'b1, 4'hC, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_outs("load out1", 1'b0, 4'h5, 1'b1, 4'hC);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 4'(k), 1'b1, 1'b0);
      #1;
      chk($sformatf("stream%0d in_ready", k), {7'd0, in_ready}, 8'd1);
      @(posedge clk);
      #1;
      chk_outs($sformatf("stream%0d", k), 1'b1, 4'(k), 1'b1, 4'hC);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk_outs("drain both", 1'b0, 4'h8, 1'b0, 4'hC);

`ifdef STREAM_DEMUX_2_COUNT_EN
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int k = 0; k < 257; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 4'(k), 1'b1, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("wrap cnt0", cnt0, 8'd1);
    chk("wrap cnt1", cnt1, 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_demux_2.md
STREAM_DEMUX_2 -- requirements
Module: stream_demux_2

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of input and both outputs.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  input beat present.
REQ-005 SHALL have port in_ready  output  1  input beat accepted this cycle when in_valid is also 1.
REQ-006 SHALL have port in_data  input  WIDTH  input payload.
REQ-007 SHALL have port in_sel  input  1  destination: 0 -> output 0, 1 -> output 1.
REQ-008 SHALL have ports out0_valid/out1_valid  output  1 each  output beat present.
REQ-009 SHALL have ports out0_ready/out1_ready  input  1 each  downstream accepts beat.
REQ-010 SHALL have ports out0_data/out1_data  output  WIDTH each  output payload.

Function
REQ-011 Transfer SHALL occur on any interface when valid and ready are both 1 at a rising edge.
REQ-012 Each output SHALL own one holding register (valid bit plus WIDTH data).
REQ-013 in_ready SHALL be combinational: ~outN_valid | outN_ready, where N = in_sel.
REQ-014 An accepted input beat SHALL appear on outN_valid/outN_data the next cycle (latency 1).
REQ-015 Sustained throughput SHALL be one beat per cycle to either output while that output's ready stays 1.
REQ-016 An output SHALL clear outN_valid after a transfer unless a new beat loads in the same cycle; a simultaneous drain and load keeps valid at 1 with the new data.
REQ-017 The non-selected output SHALL drain independently and stay unaffected by input traffic.
REQ-018 outN_data and outN_valid SHALL remain stable while outN_valid=1 and outN_ready=0.
REQ-019 Upstream SHALL hold in_data and in_sel stable while in_valid=1 and in_ready=0; the bench checks this and the block need not tolerate violations.
REQ-020 in_sel and in_data SHALL be ignored when in_valid=0.
REQ-021 Beat order per output SHALL equal input acceptance order for that destination; no beat is dropped or duplicated.

Reset
REQ-022 While reset=1, out0_valid and out1_valid SHALL be 0 and out0_data and out1_data SHALL be 0, regardless of clk.
REQ-023 Reset asserted mid-transfer SHALL discard held beats.
REQ-024 The first acceptance after reset SHALL occur only at the first rising edge with reset=0.

Configuration
REQ-025 Macro STREAM_DEMUX_2_COUNT_EN, when defined, SHALL add output ports cnt0 and cnt1 (8 bits each) counting completed output transfers per output.
REQ-026 Counters SHALL reset to 0, increment by 1 per output transfer, and wrap from 255 to 0.
REQ-027 Without STREAM_DEMUX_2_COUNT_EN, the counter ports and logic SHALL be absent; the remaining behaviour is identical.

Structure
REQ-028 Package demux_pkg SHALL hold the default width constant (4) and typedef dest_t (1-bit destination select).
REQ-029 Sub-module stream_hold_reg SHALL implement one holding register with valid/ready, load and drain; it SHALL be instantiated once per output.
REQ-030 Top level SHALL contain only select decode, in_ready generation and optional counters.

Verification
REQ-031 Reset check: assert reset mid-cycle while out0 holds 4'hA -> out0_valid and out0_data read 0 immediately; in_ready=1 after release.
REQ-032 Routing: send beats 3, 5, 9 with sel 0, 1, 0 and both readies at 1 -> out0 shows 3 then 9, out1 shows 5, each one cycle after acceptance.
REQ-033 Backpressure: out1_ready=0 with out1 holding 4'h7; present sel=1 beat 4'h2 -> in_ready=0 and out1_data stays 7; raise ready -> 7 transfers and 2 loads the same cycle.
REQ-034 Independence: out1 stalled and full; stream sel=0 beats 1..8 with out0_ready=1 -> all 8 arrive on consecutive cycles.
REQ-035 Counter (macro defined): 257 transfers on output 0 -> cnt0=1, cnt1=0.
